// File: rtl/chip8_sprite_draw.sv
// CHIP-8 DXYN sprite blitter: fetches N sprite rows from memory and XORs them into the framebuffer.
// Define CHIP8_SPRITE_CLIP_EN to skip pixels past the right/bottom edge instead of wrapping them.
module chip8_sprite_draw #(
  parameter int unsigned W_LOG2 = 6,
  parameter int unsigned H_LOG2 = 5,
  parameter int unsigned MEM_AW = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [7:0]               vx,
  input  logic [7:0]               vy,
  input  logic [3:0]               n,
  input  logic [MEM_AW-1:0]        i_addr,
  output logic                     busy,
  output logic                     done,
  output logic                     collision,
  output logic [MEM_AW-1:0]        mem_addr,
  input  logic [7:0]               mem_rdata,
  output logic [W_LOG2+H_LOG2-1:0] fb_addr,
  input  logic                     fb_rdata,
  output logic                     fb_wdata,
  output logic                     fb_we
);

  localparam int unsigned FB_AW = W_LOG2 + H_LOG2;
`ifdef CHIP8_SPRITE_CLIP_EN
  localparam int unsigned XU_W  = W_LOG2 + 4;
  localparam int unsigned YU_W  = H_LOG2 + 5;
`endif

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ROW_REQ   = 3'd1,
    ROW_LATCH = 3'd2,
    PIX_CHECK = 3'd3,
    PIX_WR    = 3'd4,
    FINISH    = 3'd5
  } state_t;

  state_t              state, state_d;
  logic [W_LOG2-1:0]   x0, x0_d;
  logic [H_LOG2-1:0]   y0, y0_d;
  logic [3:0]          n_q, n_d;
  logic [3:0]          row, row_d;
  logic [2:0]          bit_idx, bit_d;
  logic [7:0]          sprite, sprite_d;
  logic [MEM_AW-1:0]   base, base_d;
  logic [MEM_AW-1:0]   mem_addr_d;
  logic [FB_AW-1:0]    fb_addr_d;
  logic                busy_d, done_d, collision_d, fb_we_d;
  logic                adv_c;
  logic                pix_in_range_c;
  logic                pix_set_c;

  // Wrapped {y, x} address of the pixel that sprite bit b of row r lands on.
  function automatic logic [FB_AW-1:0] pix_addr(input logic [W_LOG2-1:0] xb,
                                                input logic [H_LOG2-1:0] yb,
                                                input logic [3:0] r,
                                                input logic [2:0] b);
    logic [W_LOG2-1:0] px;
    logic [H_LOG2-1:0] py;
    px = xb + W_LOG2'(3'd7 - b);
    py = yb + H_LOG2'(r);
    return {py, px};
  endfunction

`ifdef CHIP8_SPRITE_CLIP_EN
  logic [XU_W-1:0] xu_c;
  logic [YU_W-1:0] yu_c;
  always_comb begin
    xu_c           = XU_W'(x0) + XU_W'(3'd7 - bit_idx);
    yu_c           = YU_W'(y0) + YU_W'(row);
    pix_in_range_c = (xu_c < XU_W'(1 << W_LOG2)) && (yu_c < YU_W'(1 << H_LOG2));
  end
`else
  assign pix_in_range_c = 1'b1;
`endif

  assign pix_set_c = sprite[bit_idx] & pix_in_range_c;

  // Write data is the inverse of the pixel read back during PIX_WR.
  assign fb_wdata = fb_we & ~fb_rdata;

  always_comb begin
    state_d     = state;
    x0_d        = x0;
    y0_d        = y0;
    n_d         = n_q;
    row_d       = row;
    bit_d       = bit_idx;
    sprite_d    = sprite;
    base_d      = base;
    mem_addr_d  = mem_addr;
    fb_addr_d   = fb_addr;
    collision_d = collision;
    adv_c       = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          x0_d        = W_LOG2'(vx);
          y0_d        = H_LOG2'(vy);
          n_d         = n;
          base_d      = i_addr;
          row_d       = 4'd0;
          bit_d       = 3'd7;
          collision_d = 1'b0;
          state_d     = (n == 4'd0) ? FINISH : ROW_REQ;
        end
      end
      ROW_REQ:   state_d = ROW_LATCH;
      ROW_LATCH: begin
        sprite_d = mem_rdata;
        bit_d    = 3'd7;
        state_d  = PIX_CHECK;
      end
      PIX_CHECK: begin
        if (pix_set_c) state_d = PIX_WR;
        else           adv_c   = 1'b1;
      end
      PIX_WR: begin
        collision_d = collision | fb_rdata;
        adv_c       = 1'b1;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Step to the next bit, the next row, or finish.
    if (adv_c) begin
      if (bit_idx != 3'd0) begin
        bit_d   = bit_idx - 3'd1;
        state_d = PIX_CHECK;
      end else if ((row + 4'd1) < n_q) begin
        row_d   = row + 4'd1;
        state_d = ROW_REQ;
      end else begin
        state_d = FINISH;
      end
    end

    // Addresses are presented from the first cycle of the state that uses them.
    if (state_d == ROW_REQ)   mem_addr_d = base_d + MEM_AW'(row_d);
    if (state_d == PIX_CHECK) fb_addr_d  = pix_addr(x0_d, y0_d, row_d, bit_d);

    busy_d  = (state_d != IDLE);
    done_d  = (state_d == FINISH);
    fb_we_d = (state_d == PIX_WR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      x0        <= '0;
      y0        <= '0;
      n_q       <= '0;
      row       <= '0;
      bit_idx   <= '0;
      sprite    <= '0;
      base      <= '0;
      mem_addr  <= '0;
      fb_addr   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      collision <= 1'b0;
      fb_we     <= 1'b0;
    end else begin
      state     <= state_d;
      x0        <= x0_d;
      y0        <= y0_d;
      n_q       <= n_d;
      row       <= row_d;
      bit_idx   <= bit_d;
      sprite    <= sprite_d;
      base      <= base_d;
      mem_addr  <= mem_addr_d;
      fb_addr   <= fb_addr_d;
      busy      <= busy_d;
      done      <= done_d;
      collision <= collision_d;
      fb_we     <= fb_we_d;
    end
  end

endmodule

// File: tb/tb_chip8_sprite_draw.sv
// Self-checking bench for chip8_sprite_draw: directed cases plus random draws against a pixel-level model.
module tb_chip8_sprite_draw;

  localparam int SCR_W = 64;
  localparam int SCR_H = 32;
  localparam int FB_N  = 2048;
  localparam int MEM_N = 4096;
`ifdef CHIP8_SPRITE_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  vx = 8'd0;
  logic [7:0]  vy = 8'd0;
  logic [3:0]  n = 4'd0;
  logic [11:0] i_addr = 12'd0;
  logic        busy, done, collision;
  logic [11:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic [10:0] fb_addr;
  logic        fb_rdata, fb_wdata, fb_we;

  chip8_sprite_draw #(.W_LOG2(6), .H_LOG2(5), .MEM_AW(12)) dut (
    .clk(clk), .reset(reset), .start(start), .vx(vx), .vy(vy), .n(n), .i_addr(i_addr),
    .busy(busy), .done(done), .collision(collision),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .fb_addr(fb_addr), .fb_rdata(fb_rdata), .fb_wdata(fb_wdata), .fb_we(fb_we)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [MEM_N];
  logic       fb [FB_N];
  logic       model_fb [FB_N];
  logic       fb_clear = 1'b0;
  int         cyc = 0;

  // Synchronous memory and framebuffer, both with one cycle of read latency.
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    mem_rdata <= mem[mem_addr];
    fb_rdata  <= fb[fb_addr];
    if (fb_clear) begin
      for (int i = 0; i < FB_N; i++) fb[i] <= 1'b0;
    end else if (fb_we) begin
      fb[fb_addr] <= fb_wdata;
    end
  end

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  int t_acc = -1000;
  int exp_len = 0;
  bit exp_coll = 1'b0;
  bit coll_valid = 1'b0;
  int wq_addr[$];
  bit wq_data[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Expected pixel writes, latency and collision for one accepted draw.
  function automatic void model_draw(input logic [7:0] x, input logic [7:0] y,
                                     input logic [3:0] nn, input logic [11:0] a);
    logic       s [FB_N];
    int         x0, y0, ux, uy, addr, writes;
    logic [7:0] b;
    bit         c;
    for (int i = 0; i < FB_N; i++) s[i] = model_fb[i];
    wq_addr.delete();
    wq_data.delete();
    x0 = int'(x) % SCR_W;
    y0 = int'(y) % SCR_H;
    writes = 0;
    c = 1'b0;
    for (int r = 0; r < int'(nn); r++) begin
      b = mem[(int'(a) + r) % MEM_N];
      for (int col = 0; col < 8; col++) begin
        ux = x0 + col;
        uy = y0 + r;
        if (b[7-col] && (!CLIP || (ux < SCR_W && uy < SCR_H))) begin
          addr = (uy % SCR_H) * SCR_W + (ux % SCR_W);
          c = c | s[addr];
          s[addr] = ~s[addr];
          wq_addr.push_back(addr);
          wq_data.push_back(s[addr]);
          writes++;
        end
      end
    end
    exp_len = int'(nn) * 10 + writes + 1;
    exp_coll = c;
    coll_valid = 1'b1;
  endfunction

  task automatic compare_loop();
    int k;
    bit eb, ed;
    int mism;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        k  = cyc - t_acc;
        eb = (k >= 0) && (k < exp_len);
        ed = eb && (k == exp_len - 1);
        chk("busy", busy, eb);
        chk("done", done, ed);
        if (coll_valid && k >= exp_len - 1) chk("collision", collision, exp_coll);
        if (fb_we === 1'b1) begin
          if (wq_addr.size() == 0) begin
            chk("fb_we_unexpected", fb_we, 0);
          end else begin
            chk("fb_addr", fb_addr, wq_addr[0]);
            chk("fb_wdata", fb_wdata, wq_data[0]);
            model_fb[wq_addr[0]] = wq_data[0];
            void'(wq_addr.pop_front());
            void'(wq_data.pop_front());
          end
        end
        if (ed) begin
          chk("writes_left", wq_addr.size(), 0);
          mism = 0;
          for (int i = 0; i < FB_N; i++) if (fb[i] !== model_fb[i]) mism++;
          chk("fb_image", mism, 0);
        end
      end
    end
  endtask

  task automatic do_start(input logic [7:0] x, input logic [7:0] y, input logic [3:0] nn,
                          input logic [11:0] a, input bit accept);
    @(posedge clk); #1;
    start = 1'b1; vx = x; vy = y; n = nn; i_addr = a;
    if (accept) begin
      model_draw(x, y, nn, a);
      t_acc = cyc + 1;
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = -1;
    for (int j = 0; j < budget; j++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = cyc - t_acc + 1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    wq_addr.delete();
    wq_data.delete();
    exp_len = 0;
    t_acc = cyc;
    exp_coll = 1'b0;
    coll_valid = 1'b1;
  endtask

  int lat;
  int lit;

  initial begin
    fork
      compare_loop();
    join_none
    for (int i = 0; i < MEM_N; i++) mem[i] = 8'($urandom);
    mem[12'h050] = 8'hF0;
    mem[12'h100] = 8'hC0;
    mem[12'h101] = 8'hC0;
    mem[12'h400] = 8'hFF;
    for (int i = 0; i < FB_N; i++) model_fb[i] = 1'b0;
    reset = 1'b1;
    fb_clear = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    fb_clear = 1'b0;
    t_acc = cyc;
    exp_len = 0;
    coll_valid = 1'b1;
    exp_coll = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_fb_addr", fb_addr, 0);
    chk("rst_fb_we", fb_we, 0);
    chk("rst_fb_wdata", fb_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_collision", collision, 0);

    // 0xF0 at (0,0) on a clear screen.
    do_start(8'd0, 8'd0, 4'd1, 12'h050, 1'b1);
    wait_done(60, lat);
    chk("t1_latency", lat, 15);
    chk("t1_collision", collision, 0);
    repeat (2) @(posedge clk);
    for (int i = 0; i < 4; i++) chk("t1_pixel_lit", fb[i], 1);
    chk("t1_pixel4_dark", fb[4], 0);

    // Same draw again erases it and reports a collision.
    do_start(8'd0, 8'd0, 4'd1, 12'h050, 1'b1);
    wait_done(60, lat);
    chk("t2_latency", lat, 15);
    chk("t2_collision", collision, 1);
    repeat (2) @(posedge clk);
    lit = 0;
    for (int i = 0; i < FB_N; i++) if (fb[i] === 1'b1) lit++;
    chk("t2_screen_clear", lit, 0);

    // Corner draw: wraps or clips depending on build.
    do_start(8'd62, 8'd31, 4'd2, 12'h100, 1'b1);
    wait_done(80, lat);
    repeat (2) @(posedge clk);
    chk("t3_62_31", fb[31*SCR_W+62], 1);
    chk("t3_63_31", fb[31*SCR_W+63], 1);
    chk("t3_62_0", fb[62], CLIP ? 0 : 1);
    chk("t3_63_0", fb[63], CLIP ? 0 : 1);

    // n=0 finishes in one cycle with no framebuffer traffic.
    do_start(8'd5, 8'd5, 4'd0, 12'h200, 1'b1);
    wait_done(10, lat);
    chk("t4_latency", lat, 1);
    chk("t4_collision", collision, 0);
    repeat (2) @(posedge clk);

    // A start pulse while busy is ignored.
    do_start(8'd10, 8'd3, 4'd3, 12'h300, 1'b1);
    do_start(8'd40, 8'd20, 4'd4, 12'h050, 1'b0);
    wait_done(200, lat);
    chk("t5_latency", lat, exp_len);
    repeat (4) @(posedge clk);

    // Reset five cycles into an n=5 draw aborts it.
    do_start(8'd20, 8'd10, 4'd5, 12'h400, 1'b1);
    repeat (3) @(posedge clk);
    do_reset();
    @(negedge clk);
    chk("t6_busy", busy, 0);
    chk("t6_collision", collision, 0);
    repeat (3) @(posedge clk);
    do_start(8'd30, 8'd12, 4'd2, 12'h100, 1'b1);
    wait_done(100, lat);
    chk("t6_restart_latency", lat, exp_len);
    repeat (2) @(posedge clk);

    // Random draws, occasionally with an ignored start mid-draw.
    for (int t = 0; t < 40; t++) begin
      do_start(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)),
               12'($urandom_range(0, MEM_N - 1)), 1'b1);
      if (exp_len > 8 && $urandom_range(0, 3) == 0)
        do_start(8'($urandom), 8'($urandom), 4'($urandom_range(1, 15)), 12'($urandom), 1'b0);
      wait_done(400, lat);
      chk("rnd_latency", lat, exp_len);
      repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chip8_sprite_draw.md
Name: chip8_sprite_draw

Overview:
- Executes the CHIP-8 DXYN sprite draw for the top-level controller.
- Fetches N sprite bytes from Chip8_memory starting at I and XORs them into the Framebuffer at (VX,VY).
- Reports collision (VF) and a done pulse.
- Sits between the top-level controller/CPU (upstream: command) and the memory and framebuffer (downstream: read and read-modify-write ports).

Parameters:
- W_LOG2, 6, log2 of screen width in pixels (64)
- H_LOG2, 5, log2 of screen height in pixels (32)
- MEM_AW, 12, memory address width (4 KiB)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  draw request; sampled only in IDLE
- vx  in  8  X coordinate (register VX)
- vy  in  8  Y coordinate (register VY)
- n  in  4  sprite height in rows (0..15)
- i_addr  in  MEM_AW  sprite base address (register I)
- busy  out  1  high while a draw is in progress
- done  out  1  one-cycle pulse when a draw completes
- collision  out  1  1 if any lit pixel was cleared by the last draw
- mem_addr  out  MEM_AW  memory read address
- mem_rdata  in  8  memory read data; 1-cycle latency
- fb_addr  out  W_LOG2+H_LOG2  pixel address = {y, x}
- fb_rdata  in  1  pixel read data; 1-cycle latency
- fb_wdata  out  1  pixel write data
- fb_we  out  1  pixel write enable

Behaviour:
- One clock; reset is synchronous and active-high (clk, reset).
- Reset values: busy=0, done=0, collision=0, fb_we=0, fb_wdata=0, mem_addr=0, fb_addr=0; FSM enters IDLE.
- Reset asserted mid-draw aborts the draw: no further fb_we, no done pulse.
- FSM states: IDLE, ROW_REQ, ROW_LATCH, PIX_CHECK, PIX_WR, FINISH.
- IDLE: when start=1, latch the following and go to ROW_REQ:
  - x0 = vx mod 2^W_LOG2, y0 = vy mod 2^H_LOG2, n, i_addr
  - clear collision, row=0, bit=7
  - start while busy is ignored.
- IDLE with start=1 and n=0: go directly to FINISH; no memory or framebuffer access; collision=0.
- ROW_REQ: mem_addr = (i_addr + row) mod 2^MEM_AW, then ROW_LATCH.
- ROW_LATCH: latch mem_rdata into the sprite byte, bit=7, then PIX_CHECK.
- PIX_CHECK: pixel x = (x0 + (7-bit)) mod 2^W_LOG2; pixel y = (y0 + row) mod 2^H_LOG2.
  - Sprite bit set: fb_addr = {y, x}, go to PIX_WR.
  - Sprite bit clear: advance (no framebuffer access).
- PIX_WR: fb_addr unchanged; fb_we=1; fb_wdata = ~fb_rdata; collision |= fb_rdata; advance.
- Advance:
  - bit>0: bit-1, PIX_CHECK
  - else row<n-1: row+1, ROW_REQ
  - else: FINISH
- FINISH: done=1 for exactly one cycle, then IDLE.
- busy: high from the cycle after start is accepted through FINISH inclusive; low in IDLE.
- Draw latency from start edge to done pulse = n*10 + popcount(all sprite bytes) + 1 cycles; for n=0 it is 1 cycle.
- collision holds its value until the next accepted start.
- fb_we is never asserted outside PIX_WR; at most one framebuffer write per cycle.
- Sprite bits are processed MSB first; MSB maps to column x0.

Optional Feature:
- Macro CHIP8_SPRITE_CLIP_EN.
- Defined: pixels whose unwrapped x0+(7-bit) ≥ 2^W_LOG2, or y0+row ≥ 2^H_LOG2, are treated as clear bits (skipped in PIX_CHECK, 1 cycle, no framebuffer access, no collision contribution). Starting coordinates are still wrapped.
- Not defined: per-pixel coordinates wrap modulo screen size as described above.

Test Plan:
- n=1, i_addr=0x050, mem[0x050]=0xF0, vx=0, vy=0, framebuffer clear -> writes 1 to {0,0..3}; done 15 cycles after start; collision=0.
- Repeat the same draw -> pixels {0,0..3} written 0; collision=1; framebuffer fully clear afterwards.
- vx=62, vy=31, n=2, bytes 0xC0,0xC0 -> without macro, pixels (62,31),(63,31),(62,0),(63,0) lit; with CHIP8_SPRITE_CLIP_EN, only (62,31),(63,31) lit.
- n=0 with start -> done exactly 1 cycle later; fb_we never asserted; collision=0.
- Second start pulsed while busy -> ignored; single done pulse; framebuffer matches a single draw.
- reset asserted 5 cycles into an n=5 draw -> busy=0 and collision=0 next cycle; no further fb_we; a new start then completes normally.
